// File: rtl/swj_pkg.sv
// ---------------------------------------------------------------------------
// swj_pkg : shared types and constants for the SWJ switch sequencer.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

package swj_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_DELAY     = 3'd3,
    S_DRAIN     = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_BADSEL  = 2'd2,
    ST_ABORT   = 2'd3
  } status_t;

  localparam logic [15:0] JTAG_TO_SWD = 16'hE79E;
  localparam logic [15:0] SWD_TO_JTAG = 16'hE73C;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/swj_switch_sequencer_if.sv
// ---------------------------------------------------------------------------
// swj_switch_sequencer_if : go/pattern handshake to the JTAG bit banger.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

interface swj_switch_sequencer_if #(
  parameter int pPATTERN_WIDTH = 16
);
  logic [pPATTERN_WIDTH-1:0] bb_pattern;
  logic                      bb_go;
  logic                      bb_busy;
  logic                      bb_done;

  modport master (output bb_pattern, output bb_go, input bb_busy, input bb_done);
  modport slave  (input bb_pattern, input bb_go, output bb_busy, output bb_done);
endinterface

`default_nettype wire

// File: rtl/swj_switch_sequencer.sv
// ---------------------------------------------------------------------------
// swj_switch_sequencer : launches repeated TMS switch sequences on the banger,
// with inter-run gap, per-run timeout, abort/drain and status reporting.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module swj_switch_sequencer
  import swj_pkg::*;
#(
  parameter int pPATTERN_WIDTH = 16,
  parameter int pTIMEOUT_WIDTH = 24
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      start,
  input  wire logic [1:0]                sel,
  input  wire logic [pPATTERN_WIDTH-1:0] custom_pattern,
  input  wire logic [3:0]                repeat_count,
  input  wire logic [15:0]               post_delay,
  input  wire logic [pTIMEOUT_WIDTH-1:0] timeout,
  input  wire logic                      abort,
  swj_switch_sequencer_if.master         bb,
  output logic                           pin_own,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     status,
  output logic [3:0]                     seq_count
);

  state_t                    r_state;
  logic [3:0]                r_rep;
  logic [15:0]               r_delay;
  logic [15:0]               r_dly_cnt;
  logic [pTIMEOUT_WIDTH-1:0] r_timeout;
  logic [pTIMEOUT_WIDTH-1:0] r_to_cnt;
  logic                      r_low_seen;

  logic [pPATTERN_WIDTH-1:0] w_sel_pattern;
  logic [pTIMEOUT_WIDTH-1:0] w_to_inc;
  logic                      w_supervised;
  logic                      w_to_expire;

  always_comb begin
    if (sel == 2'd0)      w_sel_pattern = pPATTERN_WIDTH'(JTAG_TO_SWD);
    else if (sel == 2'd1) w_sel_pattern = pPATTERN_WIDTH'(SWD_TO_JTAG);
    else                  w_sel_pattern = custom_pattern;
  end

  // Timeout counter saturates; expiry fires in the timeout-th supervised cycle.
  assign w_to_inc     = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + pTIMEOUT_WIDTH'(1);
  assign w_supervised = (r_state == S_LAUNCH) || (r_state == S_WAIT_DONE) ||
                        (r_state == S_DRAIN);
  assign w_to_expire  = w_supervised && (r_timeout != '0) && (w_to_inc == r_timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rep         <= 4'd0;
      r_delay       <= 16'd0;
      r_dly_cnt     <= 16'd0;
      r_timeout     <= '0;
      r_to_cnt      <= '0;
      r_low_seen    <= 1'b0;
      bb.bb_pattern <= '0;
      bb.bb_go      <= 1'b0;
      pin_own       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      status        <= ST_OK;
      seq_count     <= 4'd0;
    end else begin
      done <= 1'b0;
      if (w_supervised) r_to_cnt <= w_to_inc;

      if (w_to_expire) begin
        status   <= ST_TIMEOUT;
        error    <= 1'b1;
        bb.bb_go <= 1'b0;
        r_state  <= S_FINISH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !done) begin
              if (sel == 2'd3) begin
                status  <= ST_BADSEL;
                error   <= 1'b1;
                r_state <= S_FINISH;
              end else begin
                bb.bb_pattern <= w_sel_pattern;
                r_rep         <= (repeat_count == 4'd0) ? 4'd1 : repeat_count;
                r_delay       <= post_delay;
                r_timeout     <= timeout;
                r_to_cnt      <= '0;
                seq_count     <= 4'd0;
                error         <= 1'b0;
                status        <= ST_OK;
                busy          <= 1'b1;
                pin_own       <= 1'b1;
                bb.bb_go      <= 1'b1;
                r_state       <= S_LAUNCH;
              end
            end
          end

          S_LAUNCH: begin
            if (abort) begin
              status   <= ST_ABORT;
              error    <= 1'b1;
              bb.bb_go <= 1'b0;
              r_state  <= S_FINISH;
            end else if (bb.bb_busy) begin
              bb.bb_go <= 1'b0;
              r_state  <= S_WAIT_DONE;
            end
          end

          S_WAIT_DONE: begin
            if (bb.bb_done) begin
              seq_count <= sat_inc4(seq_count);
              r_dly_cnt <= r_delay;
              if (abort) begin
                status  <= ST_ABORT;
                error   <= 1'b1;
                r_state <= S_FINISH;
              end else begin
                r_state <= S_DELAY;
              end
            end else if (abort) begin
              // Banger is mid-shift: keep the pins until it settles.
              status     <= ST_ABORT;
              error      <= 1'b1;
              bb.bb_go   <= 1'b0;
              r_low_seen <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end

          S_DELAY: begin
            if (abort) begin
              status  <= ST_ABORT;
              error   <= 1'b1;
              r_state <= S_FINISH;
            end else if (r_dly_cnt == 16'd0) begin
              if (seq_count == r_rep) begin
                r_state <= S_FINISH;
              end else begin
                r_to_cnt <= '0;
                bb.bb_go <= 1'b1;
                r_state  <= S_LAUNCH;
              end
            end else begin
              r_dly_cnt <= r_dly_cnt - 16'd1;
            end
          end

          S_DRAIN: begin
            if (bb.bb_done || (!bb.bb_busy && r_low_seen)) r_state <= S_FINISH;
            else r_low_seen <= !bb.bb_busy;
          end

          S_FINISH: begin
            done     <= 1'b1;
            busy     <= 1'b0;
            pin_own  <= 1'b0;
            bb.bb_go <= 1'b0;
            r_state  <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_swj_switch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_swj_switch_sequencer : directed table plus corner sequences, with a
// behavioural banger model on the handshake interface.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_swj_switch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] custom_pattern = 16'd0, post_delay = 16'd0;
  logic [3:0]  repeat_count = 4'd0;
  logic [23:0] timeout = 24'd0;
  logic        pin_own, busy, done, error;
  logic [1:0]  status;
  logic [3:0]  seq_count;

  always #5 clk = ~clk;

  swj_switch_sequencer_if #(.pPATTERN_WIDTH(16)) bb ();

  swj_switch_sequencer #(.pPATTERN_WIDTH(16), .pTIMEOUT_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel),
    .custom_pattern(custom_pattern), .repeat_count(repeat_count),
    .post_delay(post_delay), .timeout(timeout), .abort(abort), .bb(bb),
    .pin_own(pin_own), .busy(busy), .done(done), .error(error),
    .status(status), .seq_count(seq_count)
  );

  // Banger model: go seen while idle -> busy for run_len+1 cycles, then a done pulse.
  int run_len = 6;
  bit stuck = 1'b0;
  int m_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      bb.bb_busy <= 1'b0;
      bb.bb_done <= 1'b0;
      m_cnt      <= 0;
    end else begin
      bb.bb_done <= 1'b0;
      if (!bb.bb_busy) begin
        if (bb.bb_go) begin
          bb.bb_busy <= 1'b1;
          m_cnt      <= run_len;
        end
      end else if (!stuck) begin
        if (m_cnt == 0) begin
          bb.bb_busy <= 1'b0;
          bb.bb_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] cp;
    logic [3:0]  rc;
    logic [15:0] pd;
    logic [23:0] to;
    int          gap;
    logic [15:0] e_pat;
    logic [1:0]  e_st;
    logic        e_err;
    logic [3:0]  e_seq;
    int          e_gos;
    int          e_dcyc;
    bit          chk_data;
  } vec_t;

  vec_t tbl[6];

  // Results of the last run_cmd
  int gos, go_cyc, done_cyc, last_done, gap_bad, pin_hi, drain_bad, cyc;
  bit timed_out;

  // mode: 0 plain, 1 abort N after first bb_go fall, 2 abort N after first
  // bb_done, 3 assert reset N after first bb_done and return.
  task automatic run_cmd(input logic [1:0] s, input logic [15:0] cp, input logic [3:0] rc,
                         input logic [15:0] pd, input logic [23:0] to, input int exp_gap,
                         input int mode, input int n);
    bit prev_go = 1'b0;
    bit fired = 1'b0;
    int trig = -1;
    @(negedge clk);
    sel = s; custom_pattern = cp; repeat_count = rc; post_delay = pd; timeout = to;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; gos = 0; go_cyc = -1; done_cyc = -1; last_done = -1;
    gap_bad = 0; pin_hi = 0; drain_bad = 0; timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (bb.bb_go && !prev_go) begin
        gos++;
        if (go_cyc < 0) go_cyc = cyc;
        if (exp_gap > 0 && last_done >= 0 && (cyc - last_done) != exp_gap) gap_bad++;
      end
      if (mode == 1 && trig < 0 && prev_go && !bb.bb_go) trig = cyc;
      prev_go = bb.bb_go;
      if (pin_own) pin_hi++;
      if (bb.bb_done) begin
        if ((mode == 2 || mode == 3) && trig < 0) trig = cyc;
        last_done = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        timed_out = 1'b0;
        break;
      end
      if (fired && (!pin_own || bb.bb_go)) drain_bad++;
      abort = 1'b0;
      if (trig >= 0 && cyc == trig + n) begin
        if (mode == 3) begin
          reset = 1'b1;
          timed_out = 1'b0;
          break;
        end else if (mode != 0) begin
          abort = 1'b1;
          fired = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    check("done_within_bound", 32'(timed_out), 0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 16'h0000, 4'd1,  16'd0,  24'd0,    0, 16'hE79E, 2'd0, 1'b0, 4'd1,  1,  12, 1'b1};
    tbl[1] = '{2'd1, 16'h0000, 4'd3,  16'd10, 24'd0,   12, 16'hE73C, 2'd0, 1'b0, 4'd3,  3,  0, 1'b1};
    tbl[2] = '{2'd2, 16'h1234, 4'd0,  16'd2,  24'd0,    0, 16'h1234, 2'd0, 1'b0, 4'd1,  1,  0, 1'b1};
    tbl[3] = '{2'd3, 16'h5555, 4'd2,  16'd0,  24'd0,    0, 16'h0000, 2'd2, 1'b1, 4'd0,  0,  2, 1'b0};
    tbl[4] = '{2'd0, 16'h0000, 4'd2,  16'd3,  24'd1000, 5, 16'hE79E, 2'd0, 1'b0, 4'd2,  2,  0, 1'b1};
    tbl[5] = '{2'd2, 16'hAAAA, 4'd15, 16'd0,  24'd0,    0, 16'hAAAA, 2'd0, 1'b0, 4'd15, 15, 0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {29'd0, bb.bb_go, pin_own, busy}, 0);
    check("rst_stat", {24'd0, done, error, status, seq_count}, 0);
    check("rst_pattern", 32'(bb.bb_pattern), 0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_cmd(tbl[k].sel, tbl[k].cp, tbl[k].rc, tbl[k].pd, tbl[k].to, tbl[k].gap, 0, 0);
      check($sformatf("v%0d_status", k), 32'(status), 32'(tbl[k].e_st));
      check($sformatf("v%0d_error", k), 32'(error), 32'(tbl[k].e_err));
      check($sformatf("v%0d_go_runs", k), 32'(gos), 32'(tbl[k].e_gos));
      check($sformatf("v%0d_busy_pin_at_done", k), {30'd0, busy, pin_own}, 0);
      if (tbl[k].chk_data) begin
        check($sformatf("v%0d_pattern", k), 32'(bb.bb_pattern), 32'(tbl[k].e_pat));
        check($sformatf("v%0d_seq_count", k), 32'(seq_count), 32'(tbl[k].e_seq));
        check($sformatf("v%0d_pin_during_run", k), 32'(pin_hi > 0), 1);
      end else begin
        check($sformatf("v%0d_pin_never", k), 32'(pin_hi), 0);
      end
      if (tbl[k].gap > 0) check($sformatf("v%0d_gap_errors", k), 32'(gap_bad), 0);
      if (tbl[k].e_dcyc > 0) check($sformatf("v%0d_done_cycle", k), 32'(done_cyc), 32'(tbl[k].e_dcyc));
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", k), 32'(done), 0);
    end

    // Timeout: banger never finishes.
    stuck = 1'b1;
    run_cmd(2'd0, 16'h0, 4'd1, 16'd0, 24'd100, 0, 0, 0);
    check("to_status", 32'(status), 1);
    check("to_error", 32'(error), 1);
    check("to_pin_own", 32'(pin_own), 0);
    check("to_latency", 32'(done_cyc - go_cyc), 101);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;

    // Abort during WAIT_DONE: drain until bb_done.
    run_len = 30;
    run_cmd(2'd1, 16'h0, 4'd2, 16'd0, 24'd0, 0, 1, 5);
    check("abw_status", 32'(status), 3);
    check("abw_error", 32'(error), 1);
    check("abw_seq_count", 32'(seq_count), 0);
    check("abw_drain_pins", 32'(drain_bad), 0);
    check("abw_done_after_bbdone", 32'(done_cyc - last_done), 2);
    run_len = 6;

    // Abort during DELAY.
    run_cmd(2'd0, 16'h0, 4'd2, 16'd20, 24'd0, 0, 2, 3);
    check("abd_status", 32'(status), 3);
    check("abd_seq_count", 32'(seq_count), 1);
    check("abd_go_runs", 32'(gos), 1);

    // Reset during DELAY of a 4-run sequence.
    run_cmd(2'd1, 16'h0, 4'd4, 16'd20, 24'd0, 0, 3, 5);
    @(negedge clk);
    check("rsd_ctrl", {29'd0, bb.bb_go, pin_own, busy}, 0);
    check("rsd_stat", {24'd0, done, error, status, seq_count}, 0);
    check("rsd_pattern", 32'(bb.bb_pattern), 0);
    reset = 1'b0;
    run_cmd(2'd0, 16'h0, 4'd1, 16'd0, 24'd0, 0, 0, 0);
    check("rsd_rerun_status", 32'(status), 0);
    check("rsd_rerun_seq", 32'(seq_count), 1);
    check("rsd_rerun_pattern", 32'(bb.bb_pattern), 32'h0000E79E);
    check("rsd_rerun_done_cycle", 32'(done_cyc), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/swj_switch_sequencer.md
# swj_switch_sequencer

Control stage directly upstream of `jtag_bit_banger`. Takes a one-cycle command from the register block, selects and latches the TMS pattern, and drives the banger's go/pattern handshake. It repeats the sequence a programmed number of times, with a programmable gap between repeats. It also owns the TMS/TCK pin-mux select, supervises each run with a timeout, supports abort, and reports status back to the registers.

## Interface
- `pPATTERN_WIDTH`, 16, TMS pattern width; must match the banger.
- `pTIMEOUT_WIDTH`, 24, width of the timeout counter.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle command pulse.
- `sel`  in  2  pattern select: 0 = JTAG→SWD `16'hE79E`; 1 = SWD→JTAG `16'hE73C`; 2 = `custom_pattern`; 3 = illegal.
- `custom_pattern`  in  pPATTERN_WIDTH  pattern used when `sel`=2.
- `repeat_count`  in  4  number of runs; 0 is treated as 1.
- `post_delay`  in  16  idle clk cycles after each banger `done`.
- `timeout`  in  pTIMEOUT_WIDTH  cycle limit per run; 0 disables the timeout.
- `abort`  in  1  level or pulse; requests a stop.
- `bb_pattern`  out  pPATTERN_WIDTH  to banger `pattern`.
- `bb_go`  out  1  to banger `go`.
- `bb_busy`  in  1  from banger `busy`.
- `bb_done`  in  1  from banger `done` (one-cycle pulse).
- `pin_own`  out  1  selects banger TMS/TCK onto the pins.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; cleared by the next accepted `start`.
- `status`  out  2  0 = ok, 1 = timeout, 2 = bad select, 3 = aborted.
- `seq_count`  out  4  runs completed in the current or last sequence.

## Operation
- All outputs are registered.
- Reset values:
  - `bb_go`, `pin_own`, `busy`, `done`, `error` = 0.
  - `status` = 0, `seq_count` = 0, `bb_pattern` = 0.
- States: IDLE, LAUNCH, WAIT_DONE, DELAY, DRAIN, FINISH.
- IDLE
  - `start` is ignored in every other state.
  - `start` with `sel`=3: go to FINISH with `status`=2, `error`=1; `bb_go` never asserts.
  - Otherwise:
    - latch the pattern into `bb_pattern`, and latch `repeat_count` (0→1), `post_delay` and `timeout`;
    - clear `seq_count`, `error` and `status`;
    - set `busy` and `pin_own`, then go to LAUNCH.
- LAUNCH
  - Hold `bb_go`=1 until `bb_busy`=1 is sampled, then drop `bb_go` and go to WAIT_DONE.
  - `bb_go` must be low before the banger's `done`: the banger restarts if `go` is still high after `done`.
- WAIT_DONE
  - On `bb_done`: increment `seq_count`, load the delay counter with the latched `post_delay`, go to DELAY.
- DELAY
  - Decrement the counter each cycle.
  - When it reads 0: go to FINISH if `seq_count` equals the latched repeat count, otherwise go to LAUNCH.
- Timeout
  - The counter reloads on entry to LAUNCH and counts through LAUNCH and WAIT_DONE.
  - On reaching the latched `timeout` (when nonzero): go to FINISH with `status`=1, `error`=1.
- Abort
  - In LAUNCH or DELAY: go to FINISH.
  - In WAIT_DONE: go to DRAIN, drop `bb_go`, keep `pin_own`.
  - In both cases set `status`=3, `error`=1; `seq_count` is not incremented.
  - `abort` in IDLE or FINISH has no effect.
- DRAIN
  - Wait for `bb_done`, or for `bb_busy`=0 for 2 consecutive cycles, then go to FINISH.
  - The timeout keeps running in DRAIN.
- FINISH
  - Pulse `done`=1 for one cycle; clear `busy` and `pin_own` in the same cycle; return to IDLE.
- `status`, `error`, `seq_count` and `bb_pattern` hold their values until the next accepted `start`.
- If `abort` and a timeout expiry happen in the same cycle, timeout wins.
- If `bb_done` and `abort` happen in the same cycle in WAIT_DONE, `bb_done` is counted first and the sequencer then goes to FINISH with `status`=3.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `busy`=`pin_own`=`bb_go`=1, `bb_pattern` valid.
- `bb_go` falls in the cycle after `bb_busy`=1 is sampled.
- DELAY lasts `post_delay`+1 cycles.
- Next-run `bb_go` rises in the cycle after DELAY ends.
- `done` pulse appears 1 cycle after FINISH is entered. `busy` is 0 in the same cycle as `done`.
- Bad-select path: `done` at cycle 2.
- The next `start` is accepted from the cycle after `done`.
- Timeout counter width is `pTIMEOUT_WIDTH`; it saturates and never wraps.
- `seq_count` saturates at 15.
- `reset` mid-operation: all outputs return to reset values next cycle; the banger is reset by the same `reset`.

## Structure
- Package `swj_pkg`:
  - state enum;
  - status codes: `ST_OK`, `ST_TIMEOUT`, `ST_BADSEL`, `ST_ABORT`;
  - pattern constants `JTAG_TO_SWD` = `16'hE79E`, `SWD_TO_JTAG` = `16'hE73C`.
- One FSM module. Delay and timeout counters are inline.
- No sub-module is required; the banger is instantiated by the parent, not inside this block.

## Test plan
- `sel`=0, `repeat_count`=1, `post_delay`=0, banger model with `clk_div`=0 → `bb_pattern`=`E79E`, one `bb_go` handshake, `done` with `status`=0 and `seq_count`=1.
- `sel`=1, `repeat_count`=3, `post_delay`=10 → three banger runs; gap between `bb_done` and the next `bb_go` rise = 12 cycles; `seq_count`=3.
- `sel`=3 → `done` at cycle 2, `status`=2, `error`=1, `bb_go` never high, `pin_own` never high.
- Banger stub holds `busy` high and never pulses `done`, `timeout`=100 → `done` about 101 cycles after `bb_go`, `status`=1, `pin_own` low.
- `abort` mid-WAIT_DONE → DRAIN until `bb_done`, then `done` with `status`=3; `pin_own` held until drain completes.
- Reset asserted during DELAY of a 4-run sequence → all outputs 0 next cycle; a new `start` then runs normally.
